frv_bitwise_wb: RTL and testbench
=================================

FRV_BITWISE_WB -- requirements
Module: frv_bitwise_wb

Interface
REQ-001 SHALL provide parameter: HI_OFFSET, default 1, added to rd to form the high-half destination address, modulo 32.
REQ-002 SHALL have one clock, g_clk; reset is synchronous and active-high, named g_reset.
REQ-003 SHALL have ports, one per line:
- g_clk  in  1  core clock; all state updates on rising edge.
- g_reset  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush; kills any pending write.
- s_valid  in  1  upstream bitwise result valid.
- s_ready  out  1  block can accept a result this cycle.
- s_wide  in  1  result is 64-bit (mror): two GPR writes.
- s_rd  in  5  destination register of low half.
- s_result  in  64  bitwise unit result; [31:0] low, [63:32] high.
- gpr_wen  out  1  GPR write request.
- gpr_addr  out  5  GPR write address.
- gpr_wdata  out  32  GPR write data.
- gpr_ack  in  1  GPR write port accepted request this cycle.
- busy  out  1  write(s) pending.

Function
REQ-004 SHALL implement FSM states IDLE, WR_LO, WR_HI, plus holding registers: rd (5b), hi (32b), lo (32b), wide (1b).
REQ-005 Accept SHALL occur when s_valid && s_ready && !flush; it captures s_rd, s_result and s_wide and enters WR_LO next cycle.
REQ-006 Latency: a result accepted in cycle N SHALL drive gpr_wen (if not suppressed) in cycle N+1.
REQ-007 In WR_LO: gpr_addr=rd, gpr_wdata=lo, gpr_wen=(rd!=0)&&!flush.
REQ-008 In WR_HI: gpr_addr=(rd+HI_OFFSET) mod 32, gpr_wdata=hi, gpr_wen=(addr!=0)&&!flush.
REQ-009 A write SHALL be complete when gpr_wen && gpr_ack, or when suppressed because the address is 0; a suppressed write completes in one cycle with no gpr_wen.
REQ-010 WR_LO complete SHALL transition to WR_HI if wide, else to the final-step rule in REQ-012; an incomplete write holds state, address and data stable.
REQ-011 WR_HI complete SHALL follow REQ-012.
REQ-012 Final write complete: if a new accept occurs in the same cycle, go to WR_LO with the new data; else go to IDLE.
REQ-013 s_ready SHALL be (state==IDLE || final write completing this cycle) && !g_reset && !flush; a final write is WR_HI, or WR_LO with wide=0.
REQ-014 Narrow back-to-back results with gpr_ack held high SHALL sustain 1 result/cycle; wide results SHALL sustain 1 result per 2 cycles.
REQ-015 flush SHALL force gpr_wen=0 in the same cycle and the state to IDLE next cycle from any state, including mid-pair, discarding the pending high half; no accept occurs in a flush cycle.
REQ-016 In IDLE: gpr_wen=0, gpr_addr=0, gpr_wdata=0.
REQ-017 busy SHALL equal (state!=IDLE).
REQ-018 gpr_wen SHALL never be asserted to address 0.
REQ-019 gpr_ack while gpr_wen=0 SHALL be ignored.

Reset
REQ-020 g_reset high at a rising edge SHALL set state=IDLE and clear holding registers to 0; after reset gpr_wen=0, gpr_addr=0, gpr_wdata=0, busy=0.
REQ-021 s_ready SHALL be 0 while g_reset is high and 1 in the first cycle after reset deasserts.
REQ-022 Reset mid-pair (WR_HI) SHALL drop the high write; no gpr_wen in the cycle after reset.

Verification
REQ-023 Narrow: s_rd=5, s_result=0x0000_0000_DEAD_BEEF, gpr_ack=1 -> next cycle gpr_wen=1, addr=5, data=0xDEADBEEF; then busy=0.
REQ-024 Wide: s_rd=6, s_result=0x1111_2222_3333_4444, gpr_ack=1 -> cycle N+1 addr=6, data=0x33334444; N+2 addr=7, data=0x11112222; s_ready=0 at N+1, 1 at N+2.
REQ-025 Backpressure: wide rd=10, gpr_ack=0 for 3 cycles -> addr=10/data held stable 3 cycles, high write follows on the ack cycle +1.
REQ-026 x0/wrap: wide rd=0, result=0xAAAA_AAAA_5555_5555 -> no wen for low; addr=1, data=0xAAAAAAAA; wide rd=31 -> writes to 31 then 0 (suppressed).
REQ-027 Flush mid-pair: wide rd=2, flush asserted in WR_HI cycle -> gpr_wen=0 that cycle, IDLE next, register 3 never written.
REQ-028 Back-to-back narrow: 4 results rd=1..4 on consecutive cycles, gpr_ack=1 -> 4 consecutive write cycles, s_ready stays 1.

Source files
------------

// File: rtl/frv_bitwise_wb.sv
// frv_bitwise_wb
// Write-back stage for the bitwise unit. It takes a 32- or 64-bit result
// and turns it into one or two GPR write requests. The high half of a
// 64-bit result goes to rd+HI_OFFSET (mod 32). Writes to x0 are suppressed
// and complete immediately. A new result can be accepted in the same cycle
// that the final write of the current one completes.

module frv_bitwise_wb #(
   parameter int HI_OFFSET = 1
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        flush,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        s_wide,
   input  logic [4:0]  s_rd,
   input  logic [63:0] s_result,
   output logic        gpr_wen,
   output logic [4:0]  gpr_addr,
   output logic [31:0] gpr_wdata,
   input  logic        gpr_ack,
   output logic        busy
);

   localparam logic [4:0] HiOffset = 5'(HI_OFFSET);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  rd_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        wide_q;

   logic [4:0]  hiAddr;
   logic        writeDone;
   logic        finalDone;
   logic        accept;

   // The 5-bit add wraps naturally, which gives the mod-32 high-half address
   assign hiAddr = rd_q + HiOffset;

   // Drive the GPR write port from the holding registers; flush kills the
   // request in the same cycle and x0 is never written
   always_comb begin
      gpr_wen   = 1'b0;
      gpr_addr  = '0;
      gpr_wdata = '0;
      unique case (state_q)
         WR_LO: begin
            gpr_addr  = rd_q;
            gpr_wdata = lo_q;
            gpr_wen   = (rd_q != 5'd0) && !flush;
         end
         WR_HI: begin
            gpr_addr  = hiAddr;
            gpr_wdata = hi_q;
            gpr_wen   = (hiAddr != 5'd0) && !flush;
         end
         default: begin
            gpr_wen   = 1'b0;
            gpr_addr  = '0;
            gpr_wdata = '0;
         end
      endcase
   end

   // A write finishes on ack, or at once when it targets x0; the last write
   // of a result frees the stage so the next result can be taken this cycle
   always_comb begin
      writeDone = (state_q != IDLE) && !flush && (gpr_ack || (gpr_addr == 5'd0));
      finalDone = writeDone && ((state_q == WR_HI) || ((state_q == WR_LO) && !wide_q));
      s_ready   = ((state_q == IDLE) || finalDone) && !g_reset && !flush;
      accept    = s_valid && s_ready;
      busy      = (state_q != IDLE);
   end

   // Next-state selection: flush wins from any state, otherwise step through
   // the low write, the optional high write, and chain straight into a new
   // result when one is accepted on the final completion
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) state_d = WR_LO;
            end
            WR_LO: begin
               if (writeDone) begin
                  if (wide_q)      state_d = WR_HI;
                  else if (accept) state_d = WR_LO;
                  else             state_d = IDLE;
               end
            end
            WR_HI: begin
               if (writeDone) begin
                  if (accept) state_d = WR_LO;
                  else        state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Holding registers capture the incoming result on every accept
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         rd_q   <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         wide_q <= 1'b0;
      end else if (accept) begin
         rd_q   <= s_rd;
         hi_q   <= s_result[63:32];
         lo_q   <= s_result[31:0];
         wide_q <= s_wide;
      end
   end

endmodule

// File: tb/tb_frv_bitwise_wb.sv
// tb_frv_bitwise_wb
// Drives directed and random results into frv_bitwise_wb. A reference model
// keeps the list of write slots each accepted result owes (one per half,
// x0 slots included), and a monitor compares the DUT's write port,
// s_ready and busy against that list on every falling edge.

module tb_frv_bitwise_wb;

   localparam int TbHiOff = 1;

   logic        g_clk;
   logic        g_reset;
   logic        flush;
   logic        s_valid;
   logic        s_ready;
   logic        s_wide;
   logic [4:0]  s_rd;
   logic [63:0] s_result;
   logic        gpr_wen;
   logic [4:0]  gpr_addr;
   logic [31:0] gpr_wdata;
   logic        gpr_ack;
   logic        busy;

   int errCount   = 0;
   int checkCount = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } slot_t;

   slot_t pend[$];

   frv_bitwise_wb #(.HI_OFFSET(TbHiOff)) dut (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .flush     (flush),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_wide    (s_wide),
      .s_rd      (s_rd),
      .s_result  (s_result),
      .gpr_wen   (gpr_wen),
      .gpr_addr  (gpr_addr),
      .gpr_wdata (gpr_wdata),
      .gpr_ack   (gpr_ack),
      .busy      (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      g_clk = 1'b0;
      forever #5 g_clk = ~g_clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
      end
   endtask

   // Inputs change 1 time unit after a rising edge and stay put until the next one
   task automatic applyStimulus(input logic v, input logic w, input logic [4:0] rd,
                                input logic [63:0] res, input logic ack,
                                input logic fl, input logic rst);
      @(posedge g_clk);
      #1;
      s_valid  = v;
      s_wide   = w;
      s_rd     = rd;
      s_result = res;
      gpr_ack  = ack;
      flush    = fl;
      g_reset  = rst;
   endtask

   task automatic idleCycles(input int n, input logic ack);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, ack, 1'b0, 1'b0);
   endtask

   // Reference model and monitor. Sampled mid-cycle, the inputs show what the
   // next rising edge will see, so the slot list is advanced here to match.
   logic  hasHead;
   logic  headDone;
   logic  expWen;
   logic  expReady;
   slot_t head;
   slot_t newSlot;

   always @(negedge g_clk) begin
      if (g_reset) begin
         checkOutput("ready_in_reset", 64'(s_ready), 64'd0);
         pend.delete();
      end else begin
         hasHead = (pend.size() > 0);
         if (hasHead) head = pend[0];
         else begin
            head.addr = '0;
            head.data = '0;
         end
         expWen   = hasHead && (head.addr != 5'd0) && !flush;
         headDone = hasHead && ((head.addr == 5'd0) || gpr_ack);
         expReady = !flush && (!hasHead || ((pend.size() == 1) && headDone));

         checkOutput("busy", 64'(busy), 64'(hasHead));
         checkOutput("s_ready", 64'(s_ready), 64'(expReady));
         checkOutput("gpr_wen", 64'(gpr_wen), 64'(expWen));
         if (hasHead && !flush) begin
            checkOutput("gpr_addr", 64'(gpr_addr), 64'(head.addr));
            checkOutput("gpr_wdata", 64'(gpr_wdata), 64'(head.data));
         end else if (!hasHead) begin
            checkOutput("idle_addr", 64'(gpr_addr), 64'd0);
            checkOutput("idle_wdata", 64'(gpr_wdata), 64'd0);
         end

         if (flush) begin
            pend.delete();
         end else begin
            if (headDone) void'(pend.pop_front());
            if (s_valid && expReady) begin
               newSlot.addr = s_rd;
               newSlot.data = s_result[31:0];
               pend.push_back(newSlot);
               if (s_wide) begin
                  newSlot.addr = 5'((int'(s_rd) + TbHiOff) % 32);
                  newSlot.data = s_result[63:32];
                  pend.push_back(newSlot);
               end
            end
         end
      end
   end

   // Directed scenarios first, then a long randomized run
   logic        rV, rW, rAck, rFl, rRst;
   logic [4:0]  rRd;
   logic [63:0] rRes;

   initial begin
      g_reset  = 1'b1;
      flush    = 1'b0;
      s_valid  = 1'b0;
      s_wide   = 1'b0;
      s_rd     = '0;
      s_result = '0;
      gpr_ack  = 1'b0;

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      idleCycles(2, 1'b0);

      $display("[TB] narrow write to x5");
      applyStimulus(1'b1, 1'b0, 5'd5, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0, 1'b0);
      idleCycles(2, 1'b1);

      $display("[TB] wide write to x6/x7");
      applyStimulus(1'b1, 1'b1, 5'd6, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b0);
      idleCycles(3, 1'b1);

      $display("[TB] wide write to x10 under backpressure");
      applyStimulus(1'b1, 1'b1, 5'd10, 64'hCAFE_F00D_0BAD_F00D, 1'b0, 1'b0, 1'b0);
      idleCycles(3, 1'b0);
      idleCycles(3, 1'b1);

      $display("[TB] x0 suppression and address wrap");
      applyStimulus(1'b1, 1'b1, 5'd0, 64'hAAAA_AAAA_5555_5555, 1'b1, 1'b0, 1'b0);
      idleCycles(3, 1'b1);
      applyStimulus(1'b1, 1'b1, 5'd31, 64'h7777_8888_9999_AAAA, 1'b1, 1'b0, 1'b0);
      idleCycles(3, 1'b1);

      $display("[TB] flush in the middle of a pair");
      applyStimulus(1'b1, 1'b1, 5'd2, 64'h2222_3333_4444_5555, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 5'd9, 64'h0000_0000_1234_5678, 1'b1, 1'b1, 1'b0);
      idleCycles(3, 1'b1);

      $display("[TB] back-to-back narrow results");
      for (int i = 1; i <= 4; i++)
         applyStimulus(1'b1, 1'b0, 5'(i), 64'(32'h1000_0000 + i), 1'b1, 1'b0, 1'b0);
      idleCycles(3, 1'b1);

      $display("[TB] reset in the middle of a pair");
      applyStimulus(1'b1, 1'b1, 5'd8, 64'h8888_8888_4444_4444, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 1'b1);
      idleCycles(3, 1'b1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         rV   = ($urandom_range(0, 3) != 0);
         rW   = ($urandom_range(0, 1) == 1);
         rRd  = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) rRd = ($urandom_range(0, 1) == 1) ? 5'd31 : 5'd0;
         rRes = {32'($urandom), 32'($urandom)};
         rAck = ($urandom_range(0, 9) < 7);
         rFl  = ($urandom_range(0, 19) == 0);
         rRst = ($urandom_range(0, 99) == 0);
         applyStimulus(rV, rW, rRd, rRes, rAck, rFl, rRst);
      end
      idleCycles(6, 1'b1);
      @(posedge g_clk);
      #1;
      checkOutput("drained", 64'(pend.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
